mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between four requesters: instruction fetch, operand-1 read, operand-2 read, and stack/result write.
- Serialises accesses through a small FSM with round-robin arbitration.
- Returns read data and a one-cycle ack to the winner.
- Drives stall to the control unit while any request is outstanding.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
RD_LAT, 1, memory read latency in cycles (mem_rdata valid RD_LAT cycles after mem_re), legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  4  per-requester request; index 0 fetch, 1 op1, 2 op2, 3 stack/write
we  in  4  per-requester write-enable qualifier, sampled with req
addr  in  4*ADDR_W  per-requester address, slice i = addr[i*ADDR_W +: ADDR_W]
wdata  in  4*DATA_W  per-requester write data, same slicing
ack  out  4  one-hot completion pulse, one cycle
rdata  out  DATA_W  read data, valid while ack of a read is high
stall  out  1  to control unit: |req && !(|ack), combinational
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rr_ptr=0; lat_cnt=0.
  - ack, rdata, mem_addr, mem_wdata, mem_we, mem_re all 0.
- Arbitration happens in IDLE only.
  - Winner is the first set req bit scanning from rr_ptr upward, modulo 4.
  - Winner index, addr slice, wdata slice and we bit are registered; state goes to ISSUE.
  - rr_ptr = winner+1 (mod 4), updated on grant.
  - No req in IDLE: stay IDLE, all strobes 0.
- ISSUE, exactly one cycle:
  - mem_addr/mem_wdata driven from the latched values.
  - mem_re = !we_l; mem_we = we_l.
  - Write: next state DONE.
  - Read: lat_cnt = RD_LAT-1, next state WAIT.
- WAIT:
  - Strobes 0; mem_addr held.
  - lat_cnt == 0: capture mem_rdata into rdata register, go to DONE.
  - Otherwise decrement lat_cnt.
- DONE, exactly one cycle:
  - ack[winner]=1; rdata holds captured data (read) or 0 (write).
  - Next state IDLE.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Deassert req (or present a new access) on the cycle after ack.
- Latency from req rising with FSM in IDLE (cycle 0):
  - Write: ISSUE cycle 1, ack cycle 2.
  - Read: ISSUE cycle 1, ack cycle 2+RD_LAT.
- req dropped mid-transaction: the access still completes and ack still pulses; no abort.
- we/addr changes after grant are ignored.
- Simultaneous requests: exactly one grant per transaction; the others see stall=1 until their own ack.
  - Round-robin guarantees each requester waits at most 3 transactions.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - No ack is issued for the aborted access.
  - A memory write already strobed is not undone.
- ack is never asserted in any state other than DONE; at most one ack bit is set.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins (fetch highest). rr_ptr is removed and ignored.
- Undefined (default): round-robin as described above.

Test Plan:
- Single read: RD_LAT=1, req=0001, we=0, addr0=0x12, memory[0x12]=0xBEEF, FSM in IDLE → mem_re=1 with mem_addr=0x12 in cycle 1; ack=0001 and rdata=0xBEEF in cycle 3; stall=1 in cycles 0-2, 0 in cycle 3.
- Single write: req=1000, we=1000, addr3=0x40, wdata3=0x1234 → mem_we=1, mem_addr=0x40, mem_wdata=0x1234 in cycle 1; ack=1000 in cycle 2; a following read of 0x40 returns 0x1234.
- Contention: req=1111 held, each requester dropping req after its ack, from reset → grant order 0,1,2,3; exactly four acks; no two ack bits ever set together. With ARB_FIXED_PRIO_EN and req 0 re-asserted after each ack → requester 0 wins every time.
- Latency sweep: RD_LAT=3, read of address 0x05 holding 0x00AA → ack in cycle 5, rdata=0x00AA; mem_re high only in cycle 1.
- Drop mid-read: req0 deasserted in WAIT → ack0 still pulses in DONE; FSM returns to IDLE; stall=0 afterwards.
- Reset mid-operation: rst=0 during WAIT → outputs 0 immediately; no ack; after release, req=0010 → normal read with rr_ptr restarted at 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Four-requester arbiter for a single-port data memory: IDLE/ISSUE/WAIT/DONE FSM,
// round-robin grant by default, fixed priority (index 0 highest) when ARB_FIXED_PRIO_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1    // legal range 1..7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [3:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  stall,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t              state;
    state_t              state_n;
    logic [1:0]          grant_idx;
    logic                grant_vld;
    logic [1:0]          win_l;
    logic                we_l;
    logic [ADDR_W-1:0]   addr_l;
    logic [DATA_W-1:0]   wdata_l;
    logic [2:0]          lat_cnt;
    logic [DATA_W-1:0]   rdata_r;

`ifdef ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last (winning) assignment.
    always_comb begin
        grant_vld = |req;
        grant_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) grant_idx = 2'(i);
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 2'd0;
        end else if (state == S_IDLE && grant_vld) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (grant_vld) state_n = S_ISSUE;
            S_ISSUE: state_n = we_l ? S_DONE : S_WAIT;
            S_WAIT:  if (lat_cnt == 3'd0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Transaction is latched at grant; later changes on the requester side are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_l   <= 2'd0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            lat_cnt <= 3'd0;
            rdata_r <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        win_l   <= grant_idx;
                        we_l    <= we[grant_idx];
                        addr_l  <= addr[grant_idx*ADDR_W +: ADDR_W];
                        wdata_l <= wdata[grant_idx*DATA_W +: DATA_W];
                        rdata_r <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!we_l) lat_cnt <= LAT_INIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) rdata_r <= mem_rdata;
                    else                 lat_cnt <= lat_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from the state register only, so reset clears them immediately.
    always_comb begin
        ack       = 4'b0000;
        rdata     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        unique case (state)
            S_ISSUE: begin
                mem_addr  = addr_l;
                mem_wdata = wdata_l;
                mem_we    = we_l;
                mem_re    = !we_l;
            end
            S_WAIT: begin
                mem_addr = addr_l;
            end
            S_DONE: begin
                ack[win_l] = 1'b1;
                rdata      = rdata_r;
            end
            default: ;
        endcase
    end

    assign stall = (|req) && !(|ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each attached to a small behavioural memory with matching read latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req3, we;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic [3:0]  ack, ack3;
    logic [15:0] rdata, rdata3;
    logic        stall, stall3;
    logic [7:0]  m_addr, m3_addr;
    logic [15:0] m_wdata, m3_wdata, m_rdata, m3_rdata;
    logic        m_we, m_re, m3_we, m3_re;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] p1;
    logic [15:0] p3 [0:2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .stall(stall),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_we(m_we), .mem_re(m_re),
        .mem_rdata(m_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack3), .rdata(rdata3), .stall(stall3),
        .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_we(m3_we), .mem_re(m3_re),
        .mem_rdata(m3_rdata)
    );

    // Memory models: read data appears RD_LAT cycles after the read strobe.
    always @(posedge clk) begin
        if (pl_en)     mem1[pl_addr] <= pl_data;
        else if (m_we) mem1[m_addr]  <= m_wdata;
        p1 <= m_re ? mem1[m_addr] : 16'h0000;
    end
    assign m_rdata = p1;

    always @(posedge clk) begin
        if (pl_en)      mem3[pl_addr] <= pl_data;
        else if (m3_we) mem3[m3_addr] <= m3_wdata;
        p3[0] <= m3_re ? mem3[m3_addr] : 16'h0000;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_rdata = p3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic set_port(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
        we[i]            = w;
        addr[i*8 +: 8]   = a;
        wdata[i*16 +: 16] = d;
    endtask

    int          nacks;
    bit          multi;
    bit          stall_bad;
    logic [3:0]  drop;
    logic [3:0]  exp_ack;
    int          exp_ord [4];

    initial begin
        rst = 1'b0; req = 4'b0; req3 = 4'b0; we = 4'b0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(8'h12, 16'hBEEF);
        preload(8'h05, 16'h00AA);
        preload(8'h20, 16'h5A5A);
        preload(8'h40, 16'h0000);

        // Reset state
        look();
        check("rst_ack", ack, 4'b0000);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_maddr", m_addr, 8'h00);
        check("rst_mwdata", m_wdata, 16'h0000);
        check("rst_strobes", {m_we, m_re}, 2'b00);
        check("rst_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Single read, RD_LAT=1
        req = 4'b0001; set_port(0, 1'b0, 8'h12, 16'h0);
        look(); check("rd_c0_stall", stall, 1'b1); check("rd_c0_re", m_re, 1'b0);
        tick(); look();
        check("rd_c1_re", {m_re, m_we}, 2'b10); check("rd_c1_addr", m_addr, 8'h12);
        check("rd_c1_stall", stall, 1'b1);
        tick(); look(); check("rd_c2_ack", ack, 4'b0000); check("rd_c2_stall", stall, 1'b1);
        tick(); look();
        check("rd_c3_ack", ack, 4'b0001); check("rd_c3_rdata", rdata, 16'hBEEF);
        check("rd_c3_stall", stall, 1'b0);
        tick(); req = 4'b0000;
        look(); check("rd_c4_ack", ack, 4'b0000);

        // Single write by requester 3, then read back through requester 0
        tick();
        req = 4'b1000; set_port(3, 1'b1, 8'h40, 16'h1234);
        tick(); look();
        check("wr_c1_we", {m_we, m_re}, 2'b10); check("wr_c1_addr", m_addr, 8'h40);
        check("wr_c1_wdata", m_wdata, 16'h1234);
        tick(); look();
        check("wr_c2_ack", ack, 4'b1000); check("wr_c2_rdata", rdata, 16'h0000);
        tick(); req = 4'b0001; set_port(3, 1'b0, 8'h00, 16'h0); set_port(0, 1'b0, 8'h40, 16'h0);
        tick(); tick(); tick(); look();
        check("wrrb_ack", ack, 4'b0001); check("wrrb_rdata", rdata, 16'h1234);
        tick(); req = 4'b0000;

        // Latency sweep on the RD_LAT=3 instance
        tick();
        req3 = 4'b0001; set_port(0, 1'b0, 8'h05, 16'h0);
        for (int c = 0; c <= 5; c++) begin
            look();
            check($sformatf("lat_c%0d_re", c), m3_re, (c == 1) ? 1'b1 : 1'b0);
            check($sformatf("lat_c%0d_ack", c), ack3, (c == 5) ? 4'b0001 : 4'b0000);
            if (c == 5) check("lat_rdata", rdata3, 16'h00AA);
            tick();
        end
        req3 = 4'b0000;

        // req dropped while the read is in WAIT
        tick();
        req = 4'b0001; set_port(0, 1'b0, 8'h12, 16'h0);
        tick(); look(); check("drop_c1_re", m_re, 1'b1);
        tick(); req = 4'b0000; look(); check("drop_c2_stall", stall, 1'b0);
        tick(); look();
        check("drop_c3_ack", ack, 4'b0001); check("drop_c3_rdata", rdata, 16'hBEEF);
        tick(); look();
        check("drop_c4_ack", ack, 4'b0000); check("drop_c4_re", m_re, 1'b0);
        check("drop_c4_stall", stall, 1'b0);

        // Reset asserted during WAIT
        tick();
        req = 4'b0001; set_port(0, 1'b0, 8'h12, 16'h0);
        tick(); tick(); look();
        check("rmid_wait_addr", m_addr, 8'h12);
        rst = 1'b0; req = 4'b0000;
        #1;
        check("rmid_addr", m_addr, 8'h00);
        check("rmid_strobes", {m_we, m_re}, 2'b00);
        check("rmid_ack", ack, 4'b0000);
        tick(); look(); check("rmid_noack", ack, 4'b0000);
        tick(); rst = 1'b1; look(); check("rmid_rel_ack", ack, 4'b0000);
        tick();
        req = 4'b0010; set_port(1, 1'b0, 8'h20, 16'h0);
        tick(); look(); check("rmid_rd_re", m_re, 1'b1); check("rmid_rd_addr", m_addr, 8'h20);
        tick(); tick(); look();
        check("rmid_rd_ack", ack, 4'b0010); check("rmid_rd_rdata", rdata, 16'h5A5A);
        tick(); req = 4'b0000;

        // Contention from reset: all four requesting at once
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`ifdef ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3};
`endif
        set_port(0, 1'b0, 8'h12, 16'h0);
        set_port(1, 1'b0, 8'h20, 16'h0);
        set_port(2, 1'b0, 8'h05, 16'h0);
        set_port(3, 1'b1, 8'h41, 16'h7777);
        req = 4'b1111;
        nacks = 0; multi = 1'b0; stall_bad = 1'b0;
        for (int c = 0; c < 40 && nacks < 4; c++) begin
            look();
            drop = 4'b0000;
            if (ack != 4'b0000) begin
                if ($countones(ack) != 1) multi = 1'b1;
                exp_ack = 4'b0001 << exp_ord[nacks];
                check($sformatf("cont_grant%0d", nacks), ack, exp_ack);
`ifdef ARB_FIXED_PRIO_EN
                drop = ack & 4'b1110;
`else
                drop = ack;
`endif
                nacks++;
            end else if (stall !== 1'b1) begin
                stall_bad = 1'b1;
            end
            tick();
            req = req & ~drop;
        end
        check("cont_nacks", nacks, 4);
        check("cont_onehot", multi, 1'b0);
        check("cont_stall", stall_bad, 1'b0);
        req = 4'b0000;
        tick(); tick(); look();
        check("cont_end_ack", ack, 4'b0000);
        check("cont_end_stall", stall, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
